// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer for the LDPC encoder: loads one frame of info words, drains
// the address-generator pipeline, then reads the parity words out under FIFO backpressure.
module ldpc_enc_ctrl #(
  parameter int pT     = 24,
  parameter int pC     = 12,
  parameter int pZF    = 24,
  parameter int pDAT_W = 4,
  parameter int pPIPE  = 2,
  localparam int cBASE = pZF / pDAT_W,
  localparam int cINFO = (pT - pC) * cBASE,
  localparam int cPAR  = pC * cBASE,
  localparam int cRA_W = (cPAR > 1) ? $clog2(cPAR) : 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic              isop,
  input  logic              ieop,
  input  logic [pDAT_W-1:0] idat,
  output logic              ordy,
  output logic              oagen_clear,
  output logic              oagen_enable,
  output logic              oword_val,
  output logic [pDAT_W-1:0] oword_dat,
  input  logic              iafull,
  output logic              oread,
  output logic [cRA_W-1:0]  oraddr,
  output logic              osop,
  output logic              oeop,
  output logic              obusy,
  output logic              oerr
);

  localparam int cWC_W = $clog2(cINFO + 1);
  localparam int cFC_W = (pPIPE > 1) ? $clog2(pPIPE) : 1;
  localparam logic [cWC_W-1:0] cWC_LAST = cWC_W'(cINFO - 1);
  localparam logic [cFC_W-1:0] cFC_LAST = cFC_W'(pPIPE - 1);
  localparam logic [cRA_W-1:0] cRA_LAST = cRA_W'(cPAR - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, PARITY} state_t;

  state_t              r_state, w_state_nxt;
  logic [cWC_W-1:0]    r_wcnt, w_wcnt_nxt;
  logic [cFC_W-1:0]    r_fcnt, w_fcnt_nxt;
  logic [cRA_W-1:0]    r_raddr, w_raddr_nxt;
  logic                w_accept;
  logic                w_clear_nxt, w_enable_nxt, w_val_nxt, w_read_nxt;
  logic                w_sop_nxt, w_eop_nxt, w_err_nxt;
  logic [pDAT_W-1:0]   w_dat_nxt;
  logic [cRA_W-1:0]    w_oraddr_nxt;

  assign ordy     = iclkena & ireset & ((r_state == IDLE) | (r_state == LOAD));
  assign w_accept = ival & ordy;

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_fcnt_nxt   = r_fcnt;
    w_raddr_nxt  = r_raddr;
    w_clear_nxt  = 1'b0;
    w_enable_nxt = 1'b0;
    w_val_nxt    = 1'b0;
    w_dat_nxt    = oword_dat;
    w_read_nxt   = 1'b0;
    w_oraddr_nxt = oraddr;
    w_sop_nxt    = 1'b0;
    w_eop_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear_nxt = 1'b1;
        if (w_accept) begin
          if (isop) begin
            w_clear_nxt  = 1'b0;
            w_enable_nxt = 1'b1;
            w_val_nxt    = 1'b1;
            w_dat_nxt    = idat;
            w_wcnt_nxt   = cWC_W'(1);
            if (cINFO == 1) begin
              w_state_nxt = FLUSH;
              w_fcnt_nxt  = '0;
              w_err_nxt   = ~ieop;
            end else begin
              w_state_nxt = LOAD;
              w_err_nxt   = ieop;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_enable_nxt = 1'b1;
          w_val_nxt    = 1'b1;
          w_dat_nxt    = idat;
          w_wcnt_nxt   = r_wcnt + cWC_W'(1);
          // The frame is closed by the word count; sop/eop only flag framing errors.
          if (r_wcnt == cWC_LAST) begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = '0;
            w_err_nxt   = ~ieop | isop;
          end else begin
            w_err_nxt   = ieop | isop;
          end
        end
      end
      FLUSH: begin
        if (r_fcnt == cFC_LAST) begin
          w_state_nxt = PARITY;
          w_raddr_nxt = '0;
        end else begin
          w_fcnt_nxt = r_fcnt + cFC_W'(1);
        end
      end
      PARITY: begin
        if (!iafull) begin
          w_read_nxt   = 1'b1;
          w_oraddr_nxt = r_raddr;
          w_sop_nxt    = (r_raddr == '0);
          w_eop_nxt    = (r_raddr == cRA_LAST);
          if (r_raddr == cRA_LAST) begin
            w_state_nxt = IDLE;
            w_raddr_nxt = '0;
            w_wcnt_nxt  = '0;
          end else begin
            w_raddr_nxt = r_raddr + cRA_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Clock enable low freezes state and every registered output together.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_fcnt       <= '0;
      r_raddr      <= '0;
      oagen_clear  <= 1'b1;
      oagen_enable <= 1'b0;
      oword_val    <= 1'b0;
      oword_dat    <= '0;
      oread        <= 1'b0;
      oraddr       <= '0;
      osop         <= 1'b0;
      oeop         <= 1'b0;
      obusy        <= 1'b0;
      oerr         <= 1'b0;
    end else if (iclkena) begin
      r_state      <= w_state_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_raddr      <= w_raddr_nxt;
      oagen_clear  <= w_clear_nxt;
      oagen_enable <= w_enable_nxt;
      oword_val    <= w_val_nxt;
      oword_dat    <= w_dat_nxt;
      oread        <= w_read_nxt;
      oraddr       <= w_oraddr_nxt;
      osop         <= w_sop_nxt;
      oeop         <= w_eop_nxt;
      obusy        <= (w_state_nxt != IDLE);
      oerr         <= w_err_nxt;
    end
  end

endmodule

// File: doc/ldpc_enc_ctrl.md
# ldpc_enc_ctrl

Frame sequencer for the LDPC encoder core. Accepts one frame of information words over a valid/ready stream and drives the address generator's clear/enable pair in lockstep with the words written into the parity accumulator memory. After the pipeline drains, it reads the accumulated parity words out towards a downstream FIFO, honouring its almost-full flag. One frame is in flight at a time.

## Interface
- pT, 24, Hb matrix columns
- pC, 12, Hb matrix rows (parity columns)
- pZF, 24, expansion factor
- pDAT_W, 4, encoder word width in bits; pZF % pDAT_W == 0
- pPIPE, 2, address-generator/accumulator pipeline depth in cycles, ≥1
- Derived: cBASE = pZF/pDAT_W; cINFO = (pT-pC)*cBASE; cPAR = pC*cBASE
- iclk, in, 1, clock
- ireset, in, 1, reset, asynchronous, active-low
- iclkena, in, 1, clock enable; low freezes all state
- ival / isop / ieop, in, 1 each, input word strobe / first word / last word
- idat, in, pDAT_W, information word
- ordy, out, 1, input ready
- oagen_clear, out, 1, to address generator iclear
- oagen_enable, out, 1, to address generator ienable
- oword_val, out, 1, information word write strobe to accumulator
- oword_dat, out, pDAT_W, registered idat
- iafull, in, 1, downstream FIFO almost-full; FIFO must absorb pPIPE+1 in-flight words
- oread, out, 1, parity read strobe
- oraddr, out, clogb2(cPAR), parity read address
- osop / oeop, out, 1 each, first / last parity read
- obusy, out, 1, state != IDLE
- oerr, out, 1, one-cycle framing-error pulse

## Operation
- States: IDLE, LOAD, FLUSH, PARITY.
- Accept = ival & ordy & iclkena. ordy = iclkena & ireset & (state ∈ {IDLE, LOAD}).
- IDLE: registered oagen_clear=1 every cycle that has no accept. An accepted word with isop gives oagen_clear=0, oagen_enable=1, oword_val=1 next cycle and sets wcnt=1. If cINFO==1, go to FLUSH; otherwise go to LOAD. Accepted words without isop are dropped and pulse oerr.
- LOAD: each accept registers oagen_enable=1, oword_val=1, oword_dat=idat and increments wcnt. A cycle without an accept registers both strobes 0. The accept with wcnt==cINFO-1 moves to FLUSH.
- LOAD errors: ieop on a non-final word pulses oerr; the frame continues by count. A missing ieop on the final word also pulses oerr. isop in LOAD pulses oerr and is otherwise ignored.
- FLUSH: ordy=0 and strobes 0. Counts pPIPE cycles, then moves to PARITY with raddr=0.
- PARITY: each cycle with !iafull registers oread=1 and oraddr=raddr, then raddr++. osop is set when raddr==0 and oeop when raddr==cPAR-1. After the cPAR-1 issue, go to IDLE. iafull=1 stalls issue with oread=0 and raddr held.
- Counters: wcnt is clogb2(cINFO+1) bits and raddr is clogb2(cPAR) bits. Neither wraps; both are reset on state entry.
- iclkena=0: state, counters and all registered outputs hold. Consumers qualify strobes with iclkena, as everywhere else in the datapath.
- Reset (ireset=0, any time including mid-frame): state=IDLE, counters 0, oagen_clear=1, all other outputs 0. A partial frame is discarded.

## Timing
- All outputs except ordy are registered, with 1-cycle latency from the accept or issue decision. ordy is combinational from state.
- Word k accepted in cycle n gives oword_val/oagen_enable in cycle n+1 for the same k. The address generator and accumulator therefore see aligned strobes.
- The last info word is accepted at cycle L. FLUSH covers cycles L+1..L+pPIPE. The first PARITY issue decision is at L+1+pPIPE, so the first oread appears at L+2+pPIPE.
- With no backpressure, the frame ends after cPAR consecutive oread cycles. ordy rises in the cycle the state returns to IDLE (the cycle after the last issue decision).

## Test plan
- Defaults (cBASE=6, cINFO=72, cPAR=72), sop at cycle 0 and 72 back-to-back words with ieop on the last -> oagen_enable high cycles 1..72, oread high 75..146, osop@75, oeop@146 with oraddr=71, oerr never high, ordy high again at 146.
- Same frame with ival deasserted on every other cycle -> exactly 72 oagen_enable pulses, each aligned with oword_val and oword_dat.
- iafull high for 10 cycles mid-PARITY -> oread low those cycles, oraddr resumes with no skipped or repeated address, and the total is 72 reads.
- ieop on word 40, a stray isop on word 50, no ieop on word 72, and a non-sop word in IDLE -> oerr pulses 4 times and parity readout still occurs.
- ireset low during LOAD at word 30, then a full frame -> outputs at reset values during reset, and the second frame is identical to the first scenario.
- iclkena low for 5 cycles inside LOAD and FLUSH -> all outputs frozen, ordy=0, and the timeline shifts by exactly 5 cycles.
